// File: rtl/lsu_axi_bridge_if.sv
// AXI4-Lite bus bundle between the LSU bridge (master) and the SoC
// interconnect (slave). Single-beat read (AR/R) and write (AW/W/B) channels,
// 32-bit data, ADDR_WIDTH-bit addresses.
interface lsu_axi_bridge_if #(
    parameter int ADDR_WIDTH = 32
);
    // read address / data
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;
    // write address / data / response
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output araddr, arprot, arvalid, rready,
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arprot, arvalid, rready,
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/lsu_axi_bridge.sv
// LSU -> AXI4-Lite master bridge. Takes one single-beat load/store from the
// LSU at a time, runs it on the AXI4-Lite bus and returns a one-cycle
// completion pulse with raw read data and an error flag.
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   req_valid/wen/addr/
//   wdata/wmask             LSU request (sampled only while idle)
//   resp_valid/rdata/err    completion pulse, read word (0 for stores), !OKAY
//   busy                    high whenever a transaction is in flight
//   axi                     AXI4-Lite master port
// Every output comes straight from a flop: the comb block computes next
// values, the sequential block registers state and outputs together.
module lsu_axi_bridge #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_wen,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_wmask,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  busy,
    lsu_axi_bridge_if.master      axi
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP} state_t;

    state_t                st, st_n;
    logic [ADDR_WIDTH-1:0] araddr_r, araddr_n, awaddr_r, awaddr_n;
    logic [31:0]           wdata_r, wdata_n, rdata_r, rdata_n;
    logic [3:0]            wstrb_r, wstrb_n;
    logic                  arvalid_r, arvalid_n, rready_r, rready_n;
    logic                  awvalid_r, awvalid_n, wvalid_r, wvalid_n;
    logic                  bready_r, bready_n;
    logic                  aw_done, aw_done_n, w_done, w_done_n;
    logic                  resp_valid_n, err_r, err_n, busy_n;

    always_comb begin
        st_n         = st;
        araddr_n     = araddr_r;
        awaddr_n     = awaddr_r;
        wdata_n      = wdata_r;
        wstrb_n      = wstrb_r;
        arvalid_n    = arvalid_r;
        rready_n     = rready_r;
        awvalid_n    = awvalid_r;
        wvalid_n     = wvalid_r;
        bready_n     = bready_r;
        aw_done_n    = aw_done;
        w_done_n     = w_done;
        resp_valid_n = 1'b0;
        rdata_n      = rdata_r;
        err_n        = err_r;
        case (st)
            IDLE: if (req_valid) begin
                aw_done_n = 1'b0;
                w_done_n  = 1'b0;
                if (!req_wen) begin
                    araddr_n  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    arvalid_n = 1'b1;
                    st_n      = RD_ADDR;
                end else begin
                    awaddr_n  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    wdata_n   = req_wdata;
                    wstrb_n   = req_wmask;
                    awvalid_n = 1'b1;
                    wvalid_n  = 1'b1;
                    st_n      = WR;
                end
            end
            RD_ADDR: if (axi.arready) begin
                arvalid_n = 1'b0;
                rready_n  = 1'b1;
                st_n      = RD_DATA;
            end
            RD_DATA: if (axi.rvalid) begin
                rready_n     = 1'b0;
                resp_valid_n = 1'b1;
                rdata_n      = axi.rdata;
                err_n        = (axi.rresp != 2'b00);
                st_n         = IDLE;
            end
            WR: begin
                // AW and W complete independently; a channel's valid drops
                // right after its own handshake, the other keeps waiting.
                if (awvalid_r && axi.awready) begin
                    awvalid_n = 1'b0;
                    aw_done_n = 1'b1;
                end
                if (wvalid_r && axi.wready) begin
                    wvalid_n = 1'b0;
                    w_done_n = 1'b1;
                end
                if (aw_done_n && w_done_n) begin
                    bready_n = 1'b1;
                    st_n     = WR_RESP;
                end
            end
            WR_RESP: if (axi.bvalid) begin
                bready_n     = 1'b0;
                resp_valid_n = 1'b1;
                rdata_n      = 32'h0;
                err_n        = (axi.bresp != 2'b00);
                st_n         = IDLE;
            end
            default: st_n = IDLE;
        endcase
        // registered busy drops on the resp_valid cycle
        busy_n = (st_n != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st         <= IDLE;
            araddr_r   <= '0;
            awaddr_r   <= '0;
            wdata_r    <= '0;
            wstrb_r    <= '0;
            arvalid_r  <= 1'b0;
            rready_r   <= 1'b0;
            awvalid_r  <= 1'b0;
            wvalid_r   <= 1'b0;
            bready_r   <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            resp_valid <= 1'b0;
            rdata_r    <= '0;
            err_r      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            st         <= st_n;
            araddr_r   <= araddr_n;
            awaddr_r   <= awaddr_n;
            wdata_r    <= wdata_n;
            wstrb_r    <= wstrb_n;
            arvalid_r  <= arvalid_n;
            rready_r   <= rready_n;
            awvalid_r  <= awvalid_n;
            wvalid_r   <= wvalid_n;
            bready_r   <= bready_n;
            aw_done    <= aw_done_n;
            w_done     <= w_done_n;
            resp_valid <= resp_valid_n;
            rdata_r    <= rdata_n;
            err_r      <= err_n;
            busy       <= busy_n;
        end
    end

    assign resp_rdata  = rdata_r;
    assign resp_err    = err_r;
    assign axi.araddr  = araddr_r;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = arvalid_r;
    assign axi.rready  = rready_r;
    assign axi.awaddr  = awaddr_r;
    assign axi.awprot  = 3'b000;
    assign axi.awvalid = awvalid_r;
    assign axi.wdata   = wdata_r;
    assign axi.wstrb   = wstrb_r;
    assign axi.wvalid  = wvalid_r;
    assign axi.bready  = bready_r;
endmodule
